// File: rtl/capture_write_ctrl.sv
// -----------------------------------------------------------------------------
// capture_write_ctrl
//   Sequences packet capture from the MAC-side word stream into a circular
//   buffer in SDRAM through an Avalon-MM write master (one word per transfer).
//
//   Configuration comes from the H2F register bank:
//     control[2] CAPT_EN, control[3] CLEAR (other bits ignored),
//     capt_buf_start (byte base, word aligned), capt_buf_size (bytes, word
//     multiple, non-zero). Both are latched when the block leaves IDLE.
//
//   Ports
//     clk, reset            : clock, asynchronous active-low reset
//     control               : CAPT_EN / CLEAR
//     capt_buf_start/_size  : buffer window
//     st_data/valid/sop/eop : packet stream in, st_ready back-pressure out
//     avm_address/write/
//     avm_writedata         : write master, stalled by avm_waitrequest
//     state                 : 00 IDLE, 01 ARMED, 10 CAPTURE, 11 ERROR
//     busy                  : in CAPTURE or a write outstanding
//     done, capt_buf_wrap   : sticky status, cleared by CLEAR (level)
//     last_write_addr       : address of the most recently completed write
// -----------------------------------------------------------------------------
module capture_write_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] control,
  input  logic [N-1:0] capt_buf_start,
  input  logic [N-1:0] capt_buf_size,
  input  logic [N-1:0] st_data,
  input  logic         st_valid,
  input  logic         st_sop,
  input  logic         st_eop,
  output logic         st_ready,
  output logic [N-1:0] avm_address,
  output logic         avm_write,
  output logic [N-1:0] avm_writedata,
  input  logic         avm_waitrequest,
  output logic [1:0]   state,
  output logic         busy,
  output logic         done,
  output logic         capt_buf_wrap,
  output logic [N-1:0] last_write_addr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_ERROR   = 2'b11
  } state_t;

  state_t cur_st, nxt_st;

  logic capt_en, clr;
  assign capt_en = control[2];
  assign clr     = control[3];

  // Remaining control bits are reserved.
  logic unused_ctrl;
  assign unused_ctrl = ^{control[N-1:4], control[1:0]};

  // Latched configuration and running write offset within the buffer.
  logic [N-1:0] start_q, size_q, offset_q;
  // The word in the write register is the last one of its packet.
  logic         eop_q;

  logic         cfg_bad, latch;
  logic         wr_done, pkt_end, wrap_hit;
  logic [N:0]   off_sum;
  logic [N-1:0] off_adv, off_cur;
  logic         accept, load;

  assign cfg_bad = (capt_buf_size == '0) | (|capt_buf_size[1:0]) |
                   (|capt_buf_start[1:0]);

  assign wr_done = avm_write & ~avm_waitrequest;
  assign pkt_end = wr_done & eop_q;

  // One extra bit so offset+4 cannot overflow against a size near 2^N.
  assign off_sum  = {1'b0, offset_q} + (N+1)'(4);
  assign wrap_hit = off_sum >= {1'b0, size_q};
  assign off_adv  = wrap_hit ? '0 : off_sum[N-1:0];
  // A word loaded in the same cycle another completes takes the advanced
  // offset; this is what allows back-to-back writes.
  assign off_cur  = wr_done ? off_adv : offset_q;

  // ---------------------------------------------------------------------------
  // Stream back-pressure
  // ---------------------------------------------------------------------------
  always_comb begin
    st_ready = 1'b0;
    case (cur_st)
      S_ARMED:   st_ready = 1'b1;
      // Free register or one draining this cycle; hold off anything after eop.
      S_CAPTURE: st_ready = ~(avm_write & eop_q) &
                            (~avm_write | ~avm_waitrequest);
      default:   st_ready = 1'b0;
    endcase
  end

  assign accept = st_valid & st_ready;
  // In ARMED only a sop starts a packet (and only while still enabled);
  // other words are swallowed. In CAPTURE everything is data, sop included.
  assign load   = accept & (((cur_st == S_ARMED) & capt_en & st_sop) |
                            (cur_st == S_CAPTURE));
  assign latch  = (cur_st == S_IDLE) & capt_en & ~cfg_bad;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_st <= S_IDLE;
    else        cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE: begin
        if (capt_en) nxt_st = cfg_bad ? S_ERROR : S_ARMED;
      end
      S_ARMED: begin
        // Disable wins over a same-cycle sop: that word is dropped.
        if (!capt_en)              nxt_st = S_IDLE;
        else if (accept && st_sop) nxt_st = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A packet is never truncated; CAPT_EN is looked at only at its end.
        if (pkt_end) nxt_st = capt_en ? S_ARMED : S_IDLE;
      end
      S_ERROR: begin
        if (!capt_en) nxt_st = S_IDLE;
      end
      default: nxt_st = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Configuration latch and buffer offset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q  <= '0;
      size_q   <= '0;
      offset_q <= '0;
    end else begin
      if (latch) begin
        start_q  <= capt_buf_start;
        size_q   <= capt_buf_size;
        offset_q <= '0;
      end else if (wr_done) begin
        offset_q <= off_adv;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write register: held unchanged while the slave stalls
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      eop_q         <= 1'b0;
    end else begin
      if (load) begin
        avm_write     <= 1'b1;
        avm_address   <= start_q + off_cur;
        avm_writedata <= st_data;
        eop_q         <= st_eop;
      end else if (wr_done) begin
        avm_write <= 1'b0;
        eop_q     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status back to the register bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done            <= 1'b0;
      capt_buf_wrap   <= 1'b0;
      last_write_addr <= '0;
    end else begin
      if (wr_done) last_write_addr <= avm_address;

      // CLEAR beats any same-cycle set.
      if (clr)          done <= 1'b0;
      else if (pkt_end) done <= 1'b1;
      else if (latch)   done <= 1'b0;

      if (clr)                       capt_buf_wrap <= 1'b0;
      else if (wr_done && wrap_hit)  capt_buf_wrap <= 1'b1;
    end
  end

  assign state = cur_st;
  assign busy  = (cur_st == S_CAPTURE) | avm_write;

endmodule

// File: tb/tb_capture_write_ctrl.sv
module tb_capture_write_ctrl;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] control = '0;
  logic [N-1:0] capt_buf_start = '0;
  logic [N-1:0] capt_buf_size = '0;
  logic [N-1:0] st_data;
  logic         st_valid, st_sop, st_eop, st_ready;
  logic [N-1:0] avm_address, avm_writedata, last_write_addr;
  logic         avm_write, avm_waitrequest;
  logic [1:0]   state;
  logic         busy, done, capt_buf_wrap;

  capture_write_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .control(control),
    .capt_buf_start(capt_buf_start), .capt_buf_size(capt_buf_size),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .state(state), .busy(busy), .done(done), .capt_buf_wrap(capt_buf_wrap),
    .last_write_addr(last_write_addr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic sop; logic eop; } word_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } exp_t;

  word_t stim_q[$];
  exp_t  exp_q[$];
  int    comp_cyc[$];
  int    checks = 0, errors = 0;
  int    n_writes = 0;
  int    cyc = 0;
  int    wr_mode = 0;   // 0 none, 1 random, 2 two stalls per write, 3 always

  // Reference model: buffer session described by a word count since latch.
  bit          m_armed, m_err, m_in_pkt, m_dis_pend, m_done, m_wrap;
  logic [31:0] m_start, m_size, m_last;
  longint      m_wcount;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_err = 0; m_in_pkt = 0; m_dis_pend = 0;
    m_done = 0; m_wrap = 0; m_start = 0; m_size = 0; m_last = 0; m_wcount = 0;
  endtask

  task automatic model_accept(input word_t w);
    exp_t e;
    if (!m_in_pkt) begin
      if (!(m_armed && w.sop)) return;  // discarded
      m_in_pkt = 1;
    end
    e.a = m_start + 32'((m_wcount * 4) % longint'(m_size));
    e.d = w.d;
    exp_q.push_back(e);
    m_last = e.a;
    m_wcount++;
    if (((m_wcount * 4) % longint'(m_size)) == 0) m_wrap = 1;
    if (w.eop) begin
      m_in_pkt = 0;
      m_done   = 1;
      if (m_dis_pend) begin m_armed = 0; m_dis_pend = 0; end
    end
  endtask

  // Stimulus driver: one decision per cycle at the falling edge.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    st_valid = 0; st_data = '0; st_sop = 0; st_eop = 0; avm_waitrequest = 0;
    forever begin
      @(negedge clk);
      case (wr_mode)
        0: avm_waitrequest = 1'b0;
        1: avm_waitrequest = ($urandom_range(0, 99) < 35);
        2: begin
          if (avm_write) begin
            if (stall_cnt < 2) begin avm_waitrequest = 1'b1; stall_cnt++; end
            else begin avm_waitrequest = 1'b0; stall_cnt = 0; end
          end else begin
            avm_waitrequest = 1'b0; stall_cnt = 0;
          end
        end
        default: avm_waitrequest = 1'b1;
      endcase
      if (stim_q.size() > 0 && !(wr_mode == 1 && $urandom_range(0, 99) < 20)) begin
        st_valid = 1'b1; st_data = stim_q[0].d;
        st_sop = stim_q[0].sop; st_eop = stim_q[0].eop;
      end else begin
        st_valid = 1'b0; st_data = $urandom; st_sop = 1'b0; st_eop = 1'b0;
      end
      #1;
      if (reset && st_valid && st_ready) begin
        model_accept(stim_q[0]);
        void'(stim_q.pop_front());
      end
    end
  end

  // Monitor: scores completed writes and stall behaviour.
  initial begin
    bit          prev_stall;
    logic [31:0] pa, pd;
    exp_t        e;
    prev_stall = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) prev_stall = 0;
      else begin
        if (prev_stall) begin
          chk("stall_write_held", 32'(avm_write), 32'd1);
          chk("stall_addr_held", avm_address, pa);
          chk("stall_data_held", avm_writedata, pd);
        end
        if (avm_write && avm_waitrequest) begin
          chk("stall_ready_low", 32'(st_ready), 32'd0);
          prev_stall = 1; pa = avm_address; pd = avm_writedata;
        end else prev_stall = 0;
        if (avm_write && !avm_waitrequest) begin
          n_writes++;
          comp_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                     avm_address, avm_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", avm_address, e.a);
            chk("write_data", avm_writedata, e.d);
          end
        end
      end
    end
  end

  task automatic check_status(input string name);
    logic [1:0] es;
    es = m_in_pkt ? 2'b10 : m_err ? 2'b11 : m_armed ? 2'b01 : 2'b00;
    chk({name, "_state"}, 32'(state), 32'(es));
    chk({name, "_st_ready"}, 32'(st_ready), 32'(es == 2'b01));
    chk({name, "_done"}, 32'(done), 32'(m_done));
    chk({name, "_wrap"}, 32'(capt_buf_wrap), 32'(m_wrap));
    chk({name, "_last_addr"}, last_write_addr, m_last);
    chk({name, "_busy"}, 32'(busy), 32'(es == 2'b10));
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #3;
      if (stim_q.size() == 0 && exp_q.size() == 0 && !avm_write && !m_in_pkt) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_drain: timeout, %0d words and %0d writes outstanding, need 0",
               name, stim_q.size(), exp_q.size());
    end
  endtask

  task automatic enable(input logic [31:0] start, input logic [31:0] size);
    @(negedge clk);
    capt_buf_start = start; capt_buf_size = size; control[2] = 1'b1;
    if (size == 0 || size[1:0] != 0 || start[1:0] != 0) m_err = 1;
    else begin
      m_armed = 1; m_start = start; m_size = size; m_wcount = 0; m_done = 0;
    end
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic disable_capt();
    @(negedge clk);
    control[2] = 1'b0;
    if (m_in_pkt) m_dis_pend = 1;
    else m_armed = 0;
    m_err = 0;
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic clear_sticky();
    @(negedge clk);
    control[3] = 1'b1;
    m_done = 0; m_wrap = 0;
    @(negedge clk);
    control[3] = 1'b0;
    @(negedge clk);
    #3;
  endtask

  task automatic push(input logic [31:0] d, input bit sop, input bit eop);
    word_t w;
    w.d = d; w.sop = sop; w.eop = eop;
    stim_q.push_back(w);
  endtask

  initial begin
    int w0;
    bit ok;
    model_reset();
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap", 32'(capt_buf_wrap), 32'd0);
    chk("rst_last_addr", last_write_addr, 32'd0);
    chk("rst_avm_address", avm_address, 32'd0);
    chk("rst_avm_writedata", avm_writedata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic packet, no stalls: back-to-back writes.
    enable(32'h1000_0000, 32'h40);
    check_status("armed");
    comp_cyc.delete();
    push(32'hA, 1, 0); push(32'hB, 0, 0); push(32'hC, 0, 1);
    wait_drain("basic");
    chk("basic_nwrites", 32'(comp_cyc.size()), 32'd3);
    if (comp_cyc.size() == 3)
      chk("basic_back_to_back", 32'(comp_cyc[2] - comp_cyc[0]), 32'd2);
    check_status("basic");
    chk("basic_last_addr_abs", last_write_addr, 32'h1000_0008);

    // Two wait states on every write.
    wr_mode = 2;
    w0 = n_writes;
    push(32'hA, 1, 0); push(32'hB, 0, 0); push(32'hC, 0, 1);
    wait_drain("waitst");
    chk("waitst_nwrites", 32'(n_writes - w0), 32'd3);
    check_status("waitst");

    // Wrap inside an 8-byte buffer.
    wr_mode = 0;
    disable_capt();
    enable(32'h1000_0100, 32'h8);
    push(32'h11, 1, 0); push(32'h22, 0, 0); push(32'h33, 0, 1);
    wait_drain("wrap");
    check_status("wrap");
    chk("wrap_last_addr_abs", last_write_addr, 32'h1000_0100);

    // Discarded words in ARMED, disable mid-packet.
    disable_capt();
    enable(32'h2000_0000, 32'h100);
    w0 = n_writes;
    push(32'hDEAD_0001, 0, 0); push(32'hDEAD_0002, 0, 1); push(32'h5001, 1, 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (m_in_pkt) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL discard_start: packet never started, expected start within 200 cycles");
    end
    disable_capt();
    push(32'h5002, 0, 1);
    wait_drain("discard");
    chk("discard_nwrites", 32'(n_writes - w0), 32'd2);
    check_status("discard");

    // Randomized sessions with random stalls and gaps.
    wr_mode = 1;
    for (int r = 0; r < 8; r++) begin
      disable_capt();
      enable($urandom & 32'hFFFF_FFFC, 32'(4 * $urandom_range(1, 12)));
      for (int p = 0; p < 3; p++) begin
        int g, len;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) push($urandom, 0, 1'($urandom_range(0, 1)));
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++)
          push($urandom, (k == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0), k == len - 1);
      end
      wait_drain("rand");
      check_status("rand");
    end
    wr_mode = 0;

    // Config errors: bad size, unaligned start, zero size.
    disable_capt();
    w0 = n_writes;
    enable(32'h3000_0000, 32'h6);
    check_status("err_size");
    repeat (5) @(negedge clk);
    chk("err_no_writes", 32'(n_writes - w0), 32'd0);
    disable_capt();
    check_status("err_exit");
    enable(32'h3000_0002, 32'h40);
    check_status("err_start");
    disable_capt();
    enable(32'h3000_0000, 32'h0);
    check_status("err_zero");
    disable_capt();

    // CLEAR wipes done and wrap.
    enable(32'h5000_0000, 32'h8);
    push(32'h71, 1, 0); push(32'h72, 0, 1);
    wait_drain("preclr");
    check_status("preclr");
    clear_sticky();
    check_status("clear");

    // Reset while a write is stalled.
    wr_mode = 3;
    push(32'h99, 1, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (avm_write) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rstmid_start: avm_write never rose, expected within 50 cycles");
    end
    reset = 1'b0;
    #1;
    chk("rstmid_avm_write", 32'(avm_write), 32'd0);
    chk("rstmid_state", 32'(state), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_last_addr", last_write_addr, 32'd0);
    chk("rstmid_avm_address", avm_address, 32'd0);
    exp_q.delete();
    stim_q.delete();
    model_reset();
    control = '0;
    wr_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check_status("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
